// File: rtl/wb_pkg.sv
// Shared opcode/funct3 encodings and the buffered write-back entry type.
package wb_pkg;

  // Entries are sized for the widest datapath; RV32 builds use the low half.
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP_W     = 7'b0111011;
  localparam logic [6:0] OP_OP_IMM_W = 7'b0011011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_FENCE    = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic                we;
    logic [4:0]          rd;
    logic [XLEN_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment and extension; flags bad funct3 and misaligned offsets.
module wb_load_align import wb_pkg::*; #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]             raw,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [2:0]                  funct3,
  output logic [XLEN-1:0]             data,
  output logic                        illegal,
  output logic                        misaligned
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic [XLEN-1:0]  sh;
  logic [OFF_W-1:0] amask;

  assign sh = raw >> {offset, 3'b000};

  always_comb begin
    data       = '0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    amask      = '0;
    case (funct3)
      F3_LB:  data = XLEN'($signed(sh[7:0]));
      F3_LBU: data = XLEN'(sh[7:0]);
      F3_LH:  begin data = XLEN'($signed(sh[15:0])); amask = OFF_W'(1); end
      F3_LHU: begin data = XLEN'(sh[15:0]);          amask = OFF_W'(1); end
      F3_LW:  begin data = XLEN'($signed(sh[31:0])); amask = OFF_W'(3); end
      F3_LWU: begin
        if (XLEN == 64) begin data = XLEN'(sh[31:0]); amask = OFF_W'(3); end
        else illegal = 1'b1;
      end
      F3_LD: begin
        if (XLEN == 64) begin data = sh; amask = OFF_W'(7); end
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    misaligned = !illegal && (|(offset & amask));
    if (illegal || misaligned) data = '0;
  end

endmodule

// File: rtl/write_back_unit.sv
// RV32/RV64 write-back stage: classifies retiring ops, buffers results in a
// small FIFO toward the register-file port, and exposes the head for forwarding.
module write_back_unit import wb_pkg::*; #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                in_opcode,
  input  logic [2:0]                in_funct3,
  input  logic [4:0]                in_rd,
  input  logic [XLEN-1:0]           in_alu_result,
  input  logic [XLEN-1:0]           in_load_data,
  input  logic [$clog2(XLEN/8)-1:0] in_load_offset,
  input  logic [XLEN-1:0]           in_pc,
  output logic                      wb_en,
  output logic [4:0]                wb_reg,
  output logic [XLEN-1:0]           wb_data,
  input  logic                      wb_ready,
  output logic                      fwd_valid,
  output logic [4:0]                fwd_reg,
  output logic [XLEN-1:0]           fwd_data,
  output logic                      err_illegal,
  output logic                      err_misaligned,
  output logic [CNT_W-1:0]          retire_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0] ld_data;
  logic            ld_illegal, ld_misaligned;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .raw       (in_load_data),
    .offset    (in_load_offset),
    .funct3    (in_funct3),
    .data      (ld_data),
    .illegal   (ld_illegal),
    .misaligned(ld_misaligned)
  );

  // Entry formation
  logic            cls_we, cls_illegal, cls_misaligned;
  logic [XLEN-1:0] cls_data;
  wb_entry_t       new_ent;

  always_comb begin
    cls_we         = 1'b0;
    cls_data       = '0;
    cls_illegal    = 1'b0;
    cls_misaligned = 1'b0;
    case (in_opcode)
      OP_OP, OP_OP_IMM, OP_AUIPC, OP_LUI: begin
        cls_we   = 1'b1;
        cls_data = in_alu_result;
      end
      OP_OP_W, OP_OP_IMM_W: begin
        if (XLEN == 64) begin
          cls_we   = 1'b1;
          cls_data = XLEN'($signed(in_alu_result[31:0]));
        end else cls_illegal = 1'b1;
      end
      OP_LOAD: begin
        cls_we         = !ld_illegal && !ld_misaligned;
        cls_data       = ld_data;
        cls_illegal    = ld_illegal;
        cls_misaligned = ld_misaligned;
      end
      OP_JAL, OP_JALR: begin
        cls_we   = 1'b1;
        cls_data = in_pc + XLEN'(4);
      end
      OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM: ;
      default: cls_illegal = 1'b1;
    endcase
  end

  always_comb begin
    new_ent                 = '0;
    new_ent.we              = cls_we && (in_rd != 5'd0);
    new_ent.rd              = in_rd;
    new_ent.data[XLEN-1:0]  = cls_data;
  end

  // Result FIFO
  wb_entry_t        fifo [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             in_ready_q;
  wb_entry_t        head;
  logic             head_vld, push, pop;

  assign head     = fifo[rd_ptr];
  assign head_vld = (count != '0);
  assign push     = in_valid && in_ready_q;
  assign pop      = head_vld && (!head.we || wb_ready);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= new_ent;
  end

  // in_ready comes from a flop so it stays low while reset is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      in_ready_q     <= 1'b0;
      err_illegal    <= 1'b0;
      err_misaligned <= 1'b0;
      retire_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_W'(1);
        retire_count <= retire_count + CNT_W'(1);
      end
      count          <= count_nxt;
      in_ready_q     <= (count_nxt < (PTR_W+1)'(DEPTH));
      err_illegal    <= push && cls_illegal;
      err_misaligned <= push && cls_misaligned;
    end
  end

  assign in_ready  = in_ready_q;
  assign wb_en     = head_vld && head.we;
  assign wb_reg    = wb_en ? head.rd : 5'd0;
  assign wb_data   = wb_en ? head.data[XLEN-1:0] : '0;
  assign fwd_valid = wb_en;
  assign fwd_reg   = wb_reg;
  assign fwd_data  = wb_data;

endmodule

// File: tb/tb_write_back_unit.sv
// Bench for write_back_unit: directed scenarios then random traffic, each
// cycle compared against a queue-based model of the write-back stage.
module tb_write_back_unit;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic              clk, reset;
  logic              in_valid, in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rd;
  logic [XLEN-1:0]   in_alu_result, in_load_data, in_pc;
  logic [2:0]        in_load_offset;
  logic              wb_en, wb_ready;
  logic [4:0]        wb_reg, fwd_reg;
  logic [XLEN-1:0]   wb_data, fwd_data;
  logic              fwd_valid, err_illegal, err_misaligned;
  logic [CNT_W-1:0]  retire_count;

  write_back_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_load_data(in_load_data),
    .in_load_offset(in_load_offset), .in_pc(in_pc),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .err_illegal(err_illegal), .err_misaligned(err_misaligned),
    .retire_count(retire_count)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct { bit we; bit [4:0] rd; bit [63:0] data; bit ill; bit mis; } exp_t;

  exp_t      q[$];
  bit        m_ready, m_ill, m_mis;
  bit [31:0] m_ret;
  int        checks, errors;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // What the spec says the current input instruction should produce
  function automatic exp_t ref_entry();
    exp_t e;
    int unsigned size;
    bit [63:0] v, mask;
    e = '{we: 0, rd: in_rd, data: 0, ill: 0, mis: 0};
    case (in_opcode)
      7'h33, 7'h13, 7'h17, 7'h37: begin e.we = 1; e.data = in_alu_result; end
      7'h3B, 7'h1B: begin e.we = 1; e.data = {{32{in_alu_result[31]}}, in_alu_result[31:0]}; end
      7'h03: begin
        if (in_funct3 == 3'b111) e.ill = 1;
        else begin
          size = 1 << in_funct3[1:0];
          if ((in_load_offset % size) != 0) e.mis = 1;
          else begin
            v = in_load_data >> (8 * in_load_offset);
            if (size < 8) begin
              mask = (64'd1 << (8 * size)) - 64'd1;
              v = v & mask;
              if (!in_funct3[2] && v[8*size-1]) v = v | ~mask;
            end
            e.we = 1; e.data = v;
          end
        end
      end
      7'h6F, 7'h67: begin e.we = 1; e.data = in_pc + 64'd4; end
      7'h23, 7'h63, 7'h0F, 7'h73: ;
      default: e.ill = 1;
    endcase
    if (in_rd == 5'd0) e.we = 0;
    if (!e.we) e.data = 0;
    return e;
  endfunction

  // Advance one clock, updating the model from the inputs presented at the edge
  task automatic cycle();
    exp_t e;
    bit acc, een;
    bit [4:0] erd;
    bit [63:0] edata;
    acc = in_valid && m_ready;
    e = ref_entry();
    if (q.size() > 0 && (!q[0].we || wb_ready)) begin
      void'(q.pop_front());
      m_ret++;
    end
    if (acc) q.push_back(e);
    m_ill   = acc && e.ill;
    m_mis   = acc && e.mis;
    m_ready = q.size() < DEPTH;
    @(posedge clk); #1;
    een   = q.size() > 0 && q[0].we;
    erd   = een ? q[0].rd : 5'd0;
    edata = een ? q[0].data : 64'd0;
    chk("in_ready", in_ready, m_ready);
    chk("wb_en", wb_en, een);
    chk("wb_reg", wb_reg, erd);
    chk("wb_data", wb_data, edata);
    chk("fwd_valid", fwd_valid, een);
    chk("fwd_reg", fwd_reg, erd);
    chk("fwd_data", fwd_data, edata);
    chk("err_illegal", err_illegal, m_ill);
    chk("err_misaligned", err_misaligned, m_mis);
    chk("retire_count", retire_count, m_ret);
  endtask

  task automatic drive(bit [6:0] op, bit [2:0] f3, bit [4:0] rd, bit [63:0] alu,
                       bit [63:0] ld, bit [2:0] off, bit [63:0] pc);
    in_valid = 1; in_opcode = op; in_funct3 = f3; in_rd = rd;
    in_alu_result = alu; in_load_data = ld; in_load_offset = off; in_pc = pc;
  endtask

  task automatic do_reset();
    reset = 0; #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_err_ill", err_illegal, 0);
    chk("rst_retire", retire_count, 0);
    q.delete(); m_ready = 0; m_ret = 0; m_ill = 0; m_mis = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  bit [6:0]  ops [14] = '{7'h33, 7'h13, 7'h17, 7'h37, 7'h3B, 7'h1B, 7'h03,
                          7'h03, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h73, 7'h00};
  bit [2:0]  ld_f3  [4] = '{3'd0, 3'd5, 3'd2, 3'd1};
  bit [2:0]  ld_off [4] = '{3'd7, 3'd2, 3'd4, 3'd1};
  bit [63:0] ld_exp [4] = '{64'hFFFFFFFFFFFFFF88, 64'h4433, 64'hFFFFFFFF88776655, 64'h0};
  bit        ld_en  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    bit [31:0] r0;
    int ill_seen;
    checks = 0; errors = 0;
    reset = 1; in_valid = 0; wb_ready = 0;
    drive(7'h33, 0, 0, 0, 0, 0, 0); in_valid = 0;
    #2;
    drive(7'h33, 0, 5'd5, 64'h1234, 0, 0, 0);
    do_reset();

    // First accept after release
    wb_ready = 1;
    cycle();
    chk("ready_after_release", in_ready, 1);
    cycle();
    chk("alu_wb_en", wb_en, 1);
    chk("alu_wb_reg", wb_reg, 5);
    chk("alu_wb_data", wb_data, 64'h1234);
    in_valid = 0;
    cycle();
    chk("alu_retire", retire_count, 1);

    // Load alignment/extension
    for (int i = 0; i < 4; i++) begin
      drive(7'h03, ld_f3[i], 5'd10, 0, 64'h8877665544332211, ld_off[i], 0);
      cycle();
      chk("load_data", wb_data, ld_exp[i]);
      chk("load_en", wb_en, ld_en[i]);
      in_valid = 0;
      cycle();
    end

    // W-op sign extension and link address
    drive(7'h3B, 0, 5'd7, 64'h0000000080000000, 0, 0, 0);
    cycle(); chk("wop_data", wb_data, 64'hFFFFFFFF80000000);
    in_valid = 0; cycle();
    drive(7'h6F, 0, 5'd1, 0, 0, 0, 64'h1000);
    cycle(); chk("jal_data", wb_data, 64'h1004);
    in_valid = 0; cycle();

    // Backpressure: FIFO fills, then drains in order
    wb_ready = 0;
    drive(7'h33, 0, 5'd3, 64'h111, 0, 0, 0); cycle();
    drive(7'h33, 0, 5'd4, 64'h222, 0, 0, 0); cycle();
    chk("full_in_ready", in_ready, 0);
    drive(7'h33, 0, 5'd6, 64'h333, 0, 0, 0); cycle();
    wb_ready = 1;
    cycle();
    chk("drain_order", wb_data, 64'h222);
    cycle();
    in_valid = 0;
    repeat (3) cycle();
    chk("drain_ready", in_ready, 1);

    // Non-writing entries drain regardless of wb_ready
    wb_ready = 0; r0 = retire_count; ill_seen = 0;
    drive(7'h23, 0, 5'd9, 0, 0, 0, 0);     cycle(); ill_seen += err_illegal;
    drive(7'h33, 0, 5'd0, 64'h55, 0, 0, 0); cycle(); ill_seen += err_illegal;
    drive(7'h00, 0, 5'd8, 0, 0, 0, 0);     cycle(); ill_seen += err_illegal;
    in_valid = 0;
    repeat (2) begin cycle(); ill_seen += err_illegal; end
    chk("nowrite_retire", retire_count - r0, 3);
    chk("ill_pulses", ill_seen, 1);

    // Reset with entries buffered
    drive(7'h33, 0, 5'd11, 64'hAA, 0, 0, 0); cycle();
    drive(7'h33, 0, 5'd12, 64'hBB, 0, 0, 0); cycle();
    do_reset();
    in_valid = 0; wb_ready = 1;
    cycle();
    chk("post_rst_wb_en", wb_en, 0);
    chk("post_rst_retire", retire_count, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(ops[$urandom_range(0, 13)], 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
            {$urandom, $urandom});
      in_valid = ($urandom_range(0, 3) != 0);
      wb_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_back_unit.md
Name: write_back_unit

Overview:
- Parametrised RV32/RV64 write-back stage. It sits between the memory stage and the register-file write port.
- It classifies each retiring instruction by opcode and forms the final write data: ALU result, aligned and extended load data, W-op sign extension, or link address (pc+4).
- Results are buffered in a small FIFO with a valid/ready handshake, so a busy register-file port stalls the pipeline without losing data.
- The FIFO head is exposed as a forwarding source, and the block counts retired instructions.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
DEPTH, 2, result FIFO entries; power of two, at least 2.
CNT_W, 32, width of retire counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous active-low reset.
in_valid  input  1  memory stage presents an instruction.
in_ready  output  1  block can accept the instruction this cycle.
in_opcode  input  7  instruction opcode.
in_funct3  input  3  load size/sign select.
in_rd  input  5  destination register.
in_alu_result  input  XLEN  ALU result (includes LUI/AUIPC immediate results).
in_load_data  input  XLEN  raw aligned-word load data.
in_load_offset  input  log2(XLEN/8)  byte offset of the load within the word.
in_pc  input  XLEN  instruction pc.
wb_en  output  1  register-file write request.
wb_reg  output  5  register-file write address.
wb_data  output  XLEN  register-file write data.
wb_ready  input  1  register-file port accepts the write this cycle.
fwd_valid  output  1  head entry holds a pending write, for forwarding.
fwd_reg  output  5  head destination register.
fwd_data  output  XLEN  head write data.
err_illegal  output  1  one-cycle pulse: unknown opcode accepted.
err_misaligned  output  1  one-cycle pulse: misaligned load accepted.
retire_count  output  CNT_W  instructions retired; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset low, asynchronous): FIFO emptied; count=0; in_ready=0 during reset and 1 from the first edge after release. All of wb_en, wb_reg, wb_data, fwd_* and err_* are 0; retire_count=0.
- Handshake:
  - Accept when in_valid and in_ready.
  - in_ready = (count < DEPTH); it is registered and does not look ahead to a same-cycle pop.
- Entry formation, combinational at accept. Each entry holds {we, rd, data}.
- Opcode classes:
  - 0110011, 0010011, 0010111 (AUIPC), 0110111 (LUI): data = in_alu_result.
  - 0111011, 0011011 (W ops): data = sign-extended in_alu_result[31:0] when XLEN=64; treated as illegal when XLEN=32.
  - 0000011 (load): data = in_load_data shifted right by 8*offset, then extended per funct3:
    - 000 LB: sext8
    - 001 LH: sext16
    - 010 LW: sext32
    - 011 LD: full width
    - 100 LBU: zext8
    - 101 LHU: zext16
    - 110 LWU: zext32
    - LD/LWU are illegal when XLEN=32; funct3 111 is illegal.
  - 1101111 (JAL), 1100111 (JALR): data = in_pc + 4, modulo 2^XLEN.
  - 0100011, 1100011, 0001111, 1110011: we=0.
- Write suppression (we=0): rd==0; illegal opcode/funct3 (also pulses err_illegal the next cycle); load offset not a multiple of the access size (also pulses err_misaligned, data=0).
- Latency: an entry accepted at edge N is visible on wb_*/fwd_* after edge N; minimum latency is 1 cycle.
- Drain:
  - wb_en = head valid and head we; wb_reg/wb_data = head fields.
  - wb_reg and wb_data read 0 when wb_en=0.
  - Pop when head valid and (not we, or wb_ready). A we=0 entry drains in 1 cycle regardless of wb_ready.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Full: in_ready=0 in the cycle after count reaches DEPTH. A pop that cycle does not reopen acceptance until the following cycle.
- Forwarding: fwd_* mirror wb_en/wb_reg/wb_data. Non-head entries are not forwarded; the hazard unit must stall on count>1.
- Retire count: retire_count += 1 on every pop, including we=0 entries, and wraps.
- Reset mid-operation: all buffered entries are discarded and no write is issued.

Decomposition:
- Package wb_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_OP, OP_OP_IMM, OP_OP_W, OP_OP_IMM_W, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM);
  - funct3 load encodings;
  - the parametrised wb_entry_t struct (we, rd, data).
- One combinational sub-module, wb_load_align: takes raw data, offset and funct3; produces extended data plus illegal/misaligned flags.
- The FIFO stays inline.

Test Plan:
- Reset hold, then release with in_valid=1, opcode 0110011, rd=5, alu=0x1234 -> next cycle wb_en=1, wb_reg=5, wb_data=0x1234; with wb_ready=1, retire_count=1 after the pop.
- Loads (XLEN=64), in_load_data=0x8877665544332211:
  - LB, offset 7 -> 0xFFFFFFFFFFFFFF88
  - LHU, offset 2 -> 0x4433
  - LW, offset 4 -> 0xFFFFFFFF88776655
  - LH, offset 1 -> err_misaligned pulse, wb_en=0, retire_count still increments.
- W op 0111011 with alu=0x00000000_80000000 -> wb_data=0xFFFFFFFF80000000. JAL with pc=0x1000, rd=1 -> wb_data=0x1004.
- wb_ready=0, three back-to-back ALU accepts -> in_ready drops after 2 accepts; raise wb_ready -> entries drain in order, no loss or duplicate, in_ready returns 1.
- Store, then an ALU op with rd=0, then opcode 0000000, each with wb_ready=0 -> all drain in 1 cycle each, wb_en never asserted, err_illegal pulses once, retire_count=3.
- Assert reset with 2 entries buffered -> wb_en=0 immediately; after release count=0 and retire_count=0.
